pipeline_hazard_ctrl: RTL

//  Central stall/flush sequencer for the 5-stage pipeline registers (IF/ID, ID/EX, EX/MEM, MEM/WB).

---
 rtl/pipeline_hazard_ctrl_if.sv | 45 ++++
 rtl/pipeline_hazard_ctrl.sv | 152 +++++++++++++++
 2 files changed

// File: rtl/pipeline_hazard_ctrl_if.sv
// Hazard-control bundle between the pipeline datapath and the stall/flush sequencer.
// Latency: none, wires only.
// Backpressure: none, the controller's enables are themselves the pipeline backpressure.
interface pipeline_hazard_ctrl_if #(
    parameter int CNT_W = 32
);
    // Hazard sources observed in the datapath
    logic             idex_memread;
    logic [4:0]       idex_rtaddr;
    logic [4:0]       ifid_rsaddr;
    logic [4:0]       ifid_rtaddr;
    logic             branch_taken;
    logic             dmem_req;
    logic             dmem_ack;

    // Pipeline register controls
    logic             pc_write;
    logic             ifid_write;
    logic             ifid_flush;
    logic             idex_write;
    logic             idex_bubble;
    logic             exmem_hold;
    logic             memwb_bubble;
    logic             err;

    // Performance counters
    logic [CNT_W-1:0] stall_cycles;
    logic [CNT_W-1:0] flush_count;

    // Sequencer side: consumes hazard sources, drives register enables
    modport master (
        input  idex_memread, idex_rtaddr, ifid_rsaddr, ifid_rtaddr,
               branch_taken, dmem_req, dmem_ack,
        output pc_write, ifid_write, ifid_flush, idex_write, idex_bubble,
               exmem_hold, memwb_bubble, err, stall_cycles, flush_count
    );

    // Datapath side: reports hazard sources, obeys register enables
    modport slave (
        output idex_memread, idex_rtaddr, ifid_rsaddr, ifid_rtaddr,
               branch_taken, dmem_req, dmem_ack,
        input  pc_write, ifid_write, ifid_flush, idex_write, idex_bubble,
               exmem_hold, memwb_bubble, err, stall_cycles, flush_count
    );
endinterface

// File: rtl/pipeline_hazard_ctrl.sv
// Stall/flush sequencer for the 5-stage pipeline; optional perf counters under PIPE_PERF_CNT_EN.
// Latency: controls are combinational from registered state + current hazard inputs.
// Backpressure: a pending data-memory access freezes the front end; a hung memory traps to ERR.
module pipeline_hazard_ctrl #(
    parameter int MEM_TIMEOUT = 15,
    parameter int CNT_W       = 32
) (
    input  logic                   clk_i,
    input  logic                   rst_n_i,
    pipeline_hazard_ctrl_if.master hz
);

    typedef enum logic [1:0] {
        S_INIT     = 2'd0,
        S_RUN      = 2'd1,
        S_MEM_WAIT = 2'd2,
        S_ERR      = 2'd3
    } state_t;

    // Last tolerated wait count; one more frozen cycle traps
    localparam logic [7:0] WAIT_LAST = 8'(MEM_TIMEOUT - 1);

    state_t     state;
    state_t     state_nxt;
    logic [7:0] wait_cnt;

    logic       freeze;
    logic       load_use;

    logic       pc_write;
    logic       ifid_write;
    logic       ifid_flush;
    logic       idex_write;
    logic       idex_bubble;
    logic       exmem_hold;
    logic       memwb_bubble;

    // Memory outstanding without completion; only meaningful while the pipe is live
    assign freeze = ((state == S_RUN) || (state == S_MEM_WAIT)) && hz.dmem_req && !hz.dmem_ack;

    // Load in EX feeding an operand of the instruction in ID; r0 never creates a dependency
    assign load_use = hz.idex_memread && (hz.idex_rtaddr != 5'd0) &&
                      ((hz.idex_rtaddr == hz.ifid_rsaddr) || (hz.idex_rtaddr == hz.ifid_rtaddr));

    // State register and consecutive-wait counter
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state    <= S_INIT;
            wait_cnt <= 8'd0;
        end else begin
            state    <= state_nxt;
            wait_cnt <= freeze ? wait_cnt + 8'd1 : 8'd0;
        end
    end

    // Next-state: one INIT cycle, freeze enters/holds MEM_WAIT, timeout traps for good
    always_comb begin
        state_nxt = state;
        case (state)
            S_INIT:     state_nxt = S_RUN;
            S_RUN,
            S_MEM_WAIT: begin
                if (freeze) begin
                    state_nxt = (wait_cnt == WAIT_LAST) ? S_ERR : S_MEM_WAIT;
                end else begin
                    state_nxt = S_RUN;
                end
            end
            S_ERR:      state_nxt = S_ERR;
            default:    state_nxt = S_INIT;
        endcase
    end

    // Output decode: ERR/freeze > load-use > branch > free-running; MEM_WAIT exit cycle is plain
    always_comb begin
        pc_write     = 1'b1;
        ifid_write   = 1'b1;
        ifid_flush   = 1'b0;
        idex_write   = 1'b1;
        idex_bubble  = 1'b0;
        exmem_hold   = 1'b0;
        memwb_bubble = 1'b0;
        case (state)
            S_INIT: begin
                pc_write     = 1'b0;
                ifid_flush   = 1'b1;
                idex_bubble  = 1'b1;
                memwb_bubble = 1'b1;
            end
            S_ERR: begin
                pc_write     = 1'b0;
                ifid_write   = 1'b0;
                idex_write   = 1'b0;
                exmem_hold   = 1'b1;
                memwb_bubble = 1'b1;
            end
            default: begin
                if (freeze) begin
                    pc_write     = 1'b0;
                    ifid_write   = 1'b0;
                    idex_write   = 1'b0;
                    exmem_hold   = 1'b1;
                    memwb_bubble = 1'b1;
                end else if (state == S_RUN) begin
                    if (load_use) begin
                        pc_write    = 1'b0;
                        ifid_write  = 1'b0;
                        idex_bubble = 1'b1;
                    end else if (hz.branch_taken) begin
                        ifid_flush  = 1'b1;
                    end
                end
            end
        endcase
    end

    assign hz.pc_write     = pc_write;
    assign hz.ifid_write   = ifid_write;
    assign hz.ifid_flush   = ifid_flush;
    assign hz.idex_write   = idex_write;
    assign hz.idex_bubble  = idex_bubble;
    assign hz.exmem_hold   = exmem_hold;
    assign hz.memwb_bubble = memwb_bubble;
    assign hz.err          = (state == S_ERR);

`ifdef PIPE_PERF_CNT_EN
    logic [CNT_W-1:0] stall_cnt;
    logic [CNT_W-1:0] flush_cnt;

    // Stalls count only while the pipe is live; flushes only from real branches in RUN
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            stall_cnt <= '0;
            flush_cnt <= '0;
        end else begin
            if (((state == S_RUN) || (state == S_MEM_WAIT)) && !pc_write) begin
                stall_cnt <= stall_cnt + 1'b1;
            end
            if ((state == S_RUN) && ifid_flush) begin
                flush_cnt <= flush_cnt + 1'b1;
            end
        end
    end

    assign hz.stall_cycles = stall_cnt;
    assign hz.flush_count  = flush_cnt;
`else
    assign hz.stall_cycles = {CNT_W{1'b0}};
    assign hz.flush_count  = {CNT_W{1'b0}};
`endif

endmodule
